// File: rtl/paddle_pkg.sv
`default_nettype none
// ============================================================================
// Module   : paddle_pkg
// Purpose  : Shared mode encoding, constants and output expansion for paddle_ctrl.
// Revision : 1.0
// ============================================================================
package paddle_pkg;

    typedef enum logic [2:0] {
        PM_Y       = 3'd0,
        PM_X       = 3'd1,
        PM_INVX    = 3'd2,
        PM_PADDLE  = 3'd3,
        PM_DIGITAL = 3'd4
    } paddle_mode_t;

    localparam logic [7:0] PADDLE_CENTER = 8'h80;

    localparam logic [1:0] DIR_NONE = 2'd0;
    localparam logic [1:0] DIR_UP   = 2'd1;
    localparam logic [1:0] DIR_DOWN = 2'd2;

    // Left-aligned 12-bit expansion; callers shift right to their own width.
    function automatic logic [11:0] paddle_expand(input logic [7:0] v);
        return {v, v[7:4]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/paddle_ch.sv
`default_nettype none
// ============================================================================
// Module   : paddle_ch
// Purpose  : One channel: source mux, digital stepper with acceleration, pos reg.
//            PADDLE_SMOOTH_EN enables a one-frame IIR on modes 0..3.
// Revision : 1.0
// ============================================================================
module paddle_ch
    import paddle_pkg::*;
#(
    parameter int MAX_STEP     = 8,
    parameter int ACCEL_FRAMES = 4
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       frame_tick_i,
    input  logic [2:0] mode_i,
    input  logic [7:0] analog_x_i,
    input  logic [7:0] analog_y_i,
    input  logic [7:0] paddle_i,
    input  logic       joy_up_i,
    input  logic       joy_down_i,
    output logic [7:0] pos_o
);

    localparam logic [5:0] STEP_MAX = 6'(MAX_STEP);
    localparam logic [3:0] ACC_LAST = 4'(ACCEL_FRAMES - 1);

    logic [7:0] pos_q,   pos_d;
    logic [5:0] step_q,  step_d;
    logic [3:0] accel_q, accel_d;
    logic [1:0] dir_q,   dir_d;

    logic [7:0] w_target;
    logic       w_held;
    logic [1:0] w_dir_now;
    logic       w_reversal;
    logic [5:0] w_eff_step;
    logic [3:0] w_eff_accel;
    logic [8:0] w_up_diff;
    logic [8:0] w_dn_sum;
    logic [7:0] w_moved;

    always_comb begin
        w_target = analog_y_i + PADDLE_CENTER;
        case (mode_i)
            PM_X:      w_target = analog_x_i + PADDLE_CENTER;
            PM_INVX:   w_target = analog_x_i ^ 8'h7F;
            PM_PADDLE: w_target = paddle_i;
            default:   w_target = analog_y_i + PADDLE_CENTER;
        endcase
    end

    // A direction flip restarts acceleration before this frame's move.
    assign w_held      = joy_up_i ^ joy_down_i;
    assign w_dir_now   = joy_up_i ? DIR_UP : DIR_DOWN;
    assign w_reversal  = (dir_q != DIR_NONE) && (dir_q != w_dir_now);
    assign w_eff_step  = w_reversal ? 6'd1 : step_q;
    assign w_eff_accel = w_reversal ? 4'd0 : accel_q;
    assign w_up_diff   = {1'b0, pos_q} - {3'b000, w_eff_step};
    assign w_dn_sum    = {1'b0, pos_q} + {3'b000, w_eff_step};
    assign w_moved     = joy_up_i ? (w_up_diff[8] ? 8'h00 : w_up_diff[7:0])
                                  : (w_dn_sum[8]  ? 8'hFF : w_dn_sum[7:0]);

`ifdef PADDLE_SMOOTH_EN
    logic [8:0] w_smooth;
    assign w_smooth = {1'b0, pos_q} + {1'b0, w_target} + 9'd1;
`endif

    always_comb begin
        pos_d   = pos_q;
        step_d  = step_q;
        accel_d = accel_q;
        dir_d   = dir_q;
        if (frame_tick_i) begin
            if (mode_i == PM_DIGITAL) begin
                if (w_held) begin
                    pos_d = w_moved;
                    dir_d = w_dir_now;
                    if (w_eff_accel == ACC_LAST) begin
                        accel_d = 4'd0;
                        step_d  = (w_eff_step >= STEP_MAX) ? STEP_MAX : w_eff_step + 6'd1;
                    end else begin
                        accel_d = w_eff_accel + 4'd1;
                        step_d  = w_eff_step;
                    end
                end else begin
                    step_d  = 6'd1;
                    accel_d = 4'd0;
                    dir_d   = DIR_NONE;
                end
            end else begin
`ifdef PADDLE_SMOOTH_EN
                pos_d   = w_smooth[8:1];
`else
                pos_d   = w_target;
`endif
                step_d  = 6'd1;
                accel_d = 4'd0;
                dir_d   = DIR_NONE;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            pos_q   <= PADDLE_CENTER;
            step_q  <= 6'd1;
            accel_q <= 4'd0;
            dir_q   <= DIR_NONE;
        end else begin
            pos_q   <= pos_d;
            step_q  <= step_d;
            accel_q <= accel_d;
            dir_q   <= dir_d;
        end
    end

    assign pos_o = pos_q;

endmodule
`default_nettype wire

// File: rtl/paddle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : paddle_ctrl
// Purpose  : Multi-channel paddle conditioner, updated once per frame on vblank rise.
//            Optional smoothing via PADDLE_SMOOTH_EN (in paddle_ch).
// Revision : 1.0
// ============================================================================
module paddle_ctrl
    import paddle_pkg::*;
#(
    parameter int NUM_CH       = 2,
    parameter int OUT_W        = 8,
    parameter int MAX_STEP     = 8,
    parameter int ACCEL_FRAMES = 4
) (
    input  logic                    clk_sys,
    input  logic                    reset_n,
    input  logic                    vblank,
    input  logic [3*NUM_CH-1:0]     mode,
    input  logic [8*NUM_CH-1:0]     analog_x,
    input  logic [8*NUM_CH-1:0]     analog_y,
    input  logic [8*NUM_CH-1:0]     paddle,
    input  logic [NUM_CH-1:0]       joy_up,
    input  logic [NUM_CH-1:0]       joy_down,
    output logic [OUT_W*NUM_CH-1:0] pos_out,
    output logic                    pos_valid
);

    logic vblank_q;
    logic pos_valid_q;
    logic w_frame_tick;

    assign w_frame_tick = vblank & ~vblank_q;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            vblank_q    <= 1'b0;
            pos_valid_q <= 1'b0;
        end else begin
            vblank_q    <= vblank;
            pos_valid_q <= w_frame_tick;
        end
    end

    assign pos_valid = pos_valid_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [7:0] w_pos;

        paddle_ch #(
            .MAX_STEP     (MAX_STEP),
            .ACCEL_FRAMES (ACCEL_FRAMES)
        ) u_ch (
            .clk_sys      (clk_sys),
            .reset_n      (reset_n),
            .frame_tick_i (w_frame_tick),
            .mode_i       (mode[3*g +: 3]),
            .analog_x_i   (analog_x[8*g +: 8]),
            .analog_y_i   (analog_y[8*g +: 8]),
            .paddle_i     (paddle[8*g +: 8]),
            .joy_up_i     (joy_up[g]),
            .joy_down_i   (joy_down[g]),
            .pos_o        (w_pos)
        );

        assign pos_out[OUT_W*g +: OUT_W] = OUT_W'(paddle_expand(w_pos) >> (12 - OUT_W));
    end

endmodule
`default_nettype wire
